// File: rtl/cci_mpf_shim_canonicalize_rsp_to_afu.sv
// Response canonicalization: registers read responses to the AFU, steers every write
// response onto AFU c1Rx through a collision FIFO, and tracks outstanding requests.
// Optional statistics outputs are enabled with the CCI_MPF_RSP_STATS_EN macro.

module cci_mpf_shim_canonicalize_rsp_to_afu #(
   parameter int HDR_W         = 24,
   parameter int DATA_W        = 512,
   parameter int FIFO_DEPTH    = 4,
   parameter int ALMFULL_SLACK = 2,
   parameter int CNT_W         = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          qlp_c0rx_valid,
   input  logic                          qlp_c0rx_is_wr_rsp,
   input  logic [HDR_W-1:0]              qlp_c0rx_hdr,
   input  logic [DATA_W-1:0]             qlp_c0rx_data,
   input  logic                          qlp_c1rx_valid,
   input  logic [HDR_W-1:0]              qlp_c1rx_hdr,
   input  logic                          rd_req_issued,
   input  logic                          wr_req_issued,
   output logic                          afu_c0rx_valid,
   output logic [HDR_W-1:0]              afu_c0rx_hdr,
   output logic [DATA_W-1:0]             afu_c0rx_data,
   output logic                          afu_c1rx_valid,
   output logic [HDR_W-1:0]              afu_c1rx_hdr,
   output logic                          wr_rsp_almfull,
   output logic [CNT_W-1:0]              rd_outstanding,
   output logic [CNT_W-1:0]              wr_outstanding,
`ifdef CCI_MPF_RSP_STATS_EN
   output logic [31:0]                   stat_wr_diverted,
   output logic [$clog2(FIFO_DEPTH):0]   stat_fifo_hwm,
`endif
   output logic [2:0]                    err_flags
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = CNT_W + 2;
   localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ALMFULL_LVL = CW'(FIFO_DEPTH - ALMFULL_SLACK);

   logic                rd_rsp_s;
   logic                s0_s;
   logic                s1_s;

   logic                c0_valid_d, c0_valid_q;
   logic [HDR_W-1:0]    c0_hdr_d, c0_hdr_q;
   logic [DATA_W-1:0]   c0_data_d, c0_data_q;
   logic                c1_valid_d, c1_valid_q;
   logic [HDR_W-1:0]    c1_hdr_d, c1_hdr_q;

   logic [HDR_W-1:0]    mem_d [FIFO_DEPTH];
   logic [HDR_W-1:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_d, wr_ptr_q;
   logic [AW-1:0]       rd_ptr_d, rd_ptr_q;
   logic [AW-1:0]       wr_ptr_p1_s;
   logic [CW-1:0]       cnt_d, cnt_q;
   logic [CW-1:0]       space_s;
   logic                deq_s;
   logic                first_v_s;
   logic                second_v_s;
   logic [HDR_W-1:0]    first_hdr_s;
   logic                take1_s;
   logic                take2_s;
   logic                ovf_s;
   logic                almfull_d, almfull_q;

   logic [EW-1:0]       rd_ext_s;
   logic [EW-1:0]       wr_ext_s;
   logic                rd_und_s, rd_sat_s;
   logic                wr_und_s, wr_sat_s;
   logic [CNT_W-1:0]    rd_cnt_d, rd_cnt_q;
   logic [CNT_W-1:0]    wr_cnt_d, wr_cnt_q;
   logic [2:0]          err_d, err_q;

   assign rd_rsp_s = qlp_c0rx_valid & ~qlp_c0rx_is_wr_rsp;
   assign s0_s     = qlp_c0rx_valid &  qlp_c0rx_is_wr_rsp;
   assign s1_s     = qlp_c1rx_valid;

   // Read response pipeline stage; header and data hold when idle
   always_comb begin
      c0_valid_d = rd_rsp_s;
      if (rd_rsp_s) begin
         c0_hdr_d  = qlp_c0rx_hdr;
         c0_data_d = qlp_c0rx_data;
      end else begin
         c0_hdr_d  = c0_hdr_q;
         c0_data_d = c0_data_q;
      end
   end

   // c1 arbitration: FIFO head has priority; leftovers become ordered enqueue candidates
   always_comb begin
      c1_valid_d  = 1'b0;
      c1_hdr_d    = c1_hdr_q;
      deq_s       = 1'b0;
      first_v_s   = 1'b0;
      second_v_s  = 1'b0;
      first_hdr_s = qlp_c1rx_hdr;
      if (cnt_q != {CW{1'b0}}) begin
         c1_valid_d  = 1'b1;
         c1_hdr_d    = mem_q[rd_ptr_q];
         deq_s       = 1'b1;
         first_v_s   = s1_s | s0_s;
         second_v_s  = s1_s & s0_s;
         first_hdr_s = s1_s ? qlp_c1rx_hdr : qlp_c0rx_hdr;
      end else if (s1_s) begin
         c1_valid_d  = 1'b1;
         c1_hdr_d    = qlp_c1rx_hdr;
         first_v_s   = s0_s;
         first_hdr_s = qlp_c0rx_hdr;
      end else if (s0_s) begin
         c1_valid_d  = 1'b1;
         c1_hdr_d    = qlp_c0rx_hdr;
      end else begin
         c1_valid_d  = 1'b0;
      end
   end

   // FIFO update. Room is judged on the occupancy at the start of the cycle, so a
   // same-cycle dequeue does not make space for an incoming entry.
   always_comb begin
      space_s     = DEPTH_C - cnt_q;
      take1_s     = first_v_s  & (space_s >= CW'(1));
      take2_s     = second_v_s & (space_s >= CW'(2));
      ovf_s       = (first_v_s & ~take1_s) | (second_v_s & ~take2_s);
      wr_ptr_p1_s = wr_ptr_q + AW'(1);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (take1_s && (wr_ptr_q == AW'(i))) begin
            mem_d[i] = first_hdr_s;
         end else if (take2_s && (wr_ptr_p1_s == AW'(i))) begin
            mem_d[i] = qlp_c0rx_hdr;
         end else begin
            mem_d[i] = mem_q[i];
         end
      end
      wr_ptr_d  = wr_ptr_q + AW'(take1_s) + AW'(take2_s);
      rd_ptr_d  = rd_ptr_q + AW'(deq_s);
      cnt_d     = cnt_q + CW'(take1_s) + CW'(take2_s) - CW'(deq_s);
      almfull_d = (cnt_d >= ALMFULL_LVL);
   end

   // Outstanding counters: net change in a 2-bit-wider field, then clamp to the legal range
   always_comb begin
      rd_ext_s = {2'b00, rd_cnt_q} + EW'(rd_req_issued) - EW'(rd_rsp_s);
      wr_ext_s = {2'b00, wr_cnt_q} + EW'(wr_req_issued) - EW'(s1_s) - EW'(s0_s);
      rd_und_s = rd_ext_s[EW-1];
      rd_sat_s = ~rd_ext_s[EW-1] & rd_ext_s[EW-2];
      wr_und_s = wr_ext_s[EW-1];
      wr_sat_s = ~wr_ext_s[EW-1] & wr_ext_s[EW-2];
      if (rd_und_s) begin
         rd_cnt_d = {CNT_W{1'b0}};
      end else if (rd_sat_s) begin
         rd_cnt_d = {CNT_W{1'b1}};
      end else begin
         rd_cnt_d = rd_ext_s[CNT_W-1:0];
      end
      if (wr_und_s) begin
         wr_cnt_d = {CNT_W{1'b0}};
      end else if (wr_sat_s) begin
         wr_cnt_d = {CNT_W{1'b1}};
      end else begin
         wr_cnt_d = wr_ext_s[CNT_W-1:0];
      end
      err_d = err_q | {ovf_s, rd_sat_s | wr_sat_s, rd_und_s | wr_und_s};
   end

   // Control and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         c0_valid_q <= 1'b0;
         c0_hdr_q   <= {HDR_W{1'b0}};
         c0_data_q  <= {DATA_W{1'b0}};
         c1_valid_q <= 1'b0;
         c1_hdr_q   <= {HDR_W{1'b0}};
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         cnt_q      <= {CW{1'b0}};
         almfull_q  <= 1'b0;
         rd_cnt_q   <= {CNT_W{1'b0}};
         wr_cnt_q   <= {CNT_W{1'b0}};
         err_q      <= 3'b000;
      end else begin
         c0_valid_q <= c0_valid_d;
         c0_hdr_q   <= c0_hdr_d;
         c0_data_q  <= c0_data_d;
         c1_valid_q <= c1_valid_d;
         c1_hdr_q   <= c1_hdr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         almfull_q  <= almfull_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         err_q      <= err_d;
      end
   end

   // FIFO storage; contents are meaningless while the pointers say empty
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef CCI_MPF_RSP_STATS_EN
   logic [31:0] diverted_d, diverted_q;
   logic [CW-1:0] hwm_d, hwm_q;

   // Diversion count and FIFO high-water mark
   always_comb begin
      diverted_d = diverted_q + 32'(s0_s);
      if (cnt_d > hwm_q) begin
         hwm_d = cnt_d;
      end else begin
         hwm_d = hwm_q;
      end
   end

   // Statistics registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         diverted_q <= 32'd0;
         hwm_q      <= {CW{1'b0}};
      end else begin
         diverted_q <= diverted_d;
         hwm_q      <= hwm_d;
      end
   end

   assign stat_wr_diverted = diverted_q;
   assign stat_fifo_hwm    = hwm_q;
`endif

   assign afu_c0rx_valid = c0_valid_q;
   assign afu_c0rx_hdr   = c0_hdr_q;
   assign afu_c0rx_data  = c0_data_q;
   assign afu_c1rx_valid = c1_valid_q;
   assign afu_c1rx_hdr   = c1_hdr_q;
   assign wr_rsp_almfull = almfull_q;
   assign rd_outstanding = rd_cnt_q;
   assign wr_outstanding = wr_cnt_q;
   assign err_flags      = err_q;

endmodule
